// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage MIPS pipeline, with the mult/div busy counter.
// Optional STALL_STAT_EN macro adds a saturating stalled-cycle counter output StallCnt.
module stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Rs_D,
    input  logic [4:0]  Rt_D,
    input  logic [1:0]  TuseRs_D,
    input  logic [1:0]  TuseRt_D,
    input  logic        MdUse_D,
    input  logic [4:0]  A3_E,
    input  logic [1:0]  Tnew_E,
    input  logic [4:0]  A3_M,
    input  logic [1:0]  Tnew_M,
    input  logic        Start_E,
    input  logic        MdOp_E,
    output logic        DregEn,
    output logic        PcEn,
    output logic        EregFlush,
    output logic        Busy
`ifdef STALL_STAT_EN
    ,
    output logic [31:0] StallCnt
`endif
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYC);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYC);

    typedef enum logic {IDLE, COUNT} state_t;

    state_t     state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    logic       stall_rs, stall_rt, stall_md, stall;

    // A Tuse of 3 can never be below a Tnew of at most 2, so unused operands never stall.
    assign stall_rs = (Rs_D != 5'd0) &&
                      (((Rs_D == A3_E) && (TuseRs_D < Tnew_E)) ||
                       ((Rs_D == A3_M) && (TuseRs_D < Tnew_M)));
    assign stall_rt = (Rt_D != 5'd0) &&
                      (((Rt_D == A3_E) && (TuseRt_D < Tnew_E)) ||
                       ((Rt_D == A3_M) && (TuseRt_D < Tnew_M)));
    // Start_E covers the issue cycle, before Busy has had a chance to rise.
    assign stall_md = MdUse_D && (Busy || Start_E);
    assign stall    = stall_rs || stall_rt || stall_md;

    assign DregEn    = ~stall;
    assign PcEn      = ~stall;
    assign EregFlush = stall;
    assign Busy      = (state_q == COUNT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
        end
    end

    // A start while already counting is ignored; the count keeps running down.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            IDLE: begin
                if (Start_E) begin
                    state_n = COUNT;
                    cnt_n   = MdOp_E ? DIV_N : MULT_N;
                end
            end
            COUNT: begin
                cnt_n = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

`ifdef STALL_STAT_EN
    always_ff @(posedge Clk) begin
        if (Reset)
            StallCnt <= 32'd0;
        else if (stall && (StallCnt != 32'hFFFF_FFFF))
            StallCnt <= StallCnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus randomized traffic against a cycle-indexed model.
module tb_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  Rs_D, Rt_D, A3_E, A3_M;
    logic [1:0]  TuseRs_D, TuseRt_D, Tnew_E, Tnew_M;
    logic        MdUse_D, Start_E, MdOp_E;
    logic        DregEn, PcEn, EregFlush, Busy;
`ifdef STALL_STAT_EN
    logic [31:0] StallCnt;
`endif

    stall_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .Clk(Clk), .Reset(Reset),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .TuseRs_D(TuseRs_D), .TuseRt_D(TuseRt_D),
        .MdUse_D(MdUse_D), .A3_E(A3_E), .Tnew_E(Tnew_E), .A3_M(A3_M), .Tnew_M(Tnew_M),
        .Start_E(Start_E), .MdOp_E(MdOp_E),
        .DregEn(DregEn), .PcEn(PcEn), .EregFlush(EregFlush), .Busy(Busy)
`ifdef STALL_STAT_EN
        , .StallCnt(StallCnt)
`endif
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Model: busy is "current cycle index is within the window opened by an accepted start".
    longint cyc = 0;
    longint busy_end = -1;
    longint stat_model = 0;
    logic   obs_dreg, obs_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic bit hazard(input logic [4:0] r, input logic [1:0] tuse);
        logic [4:0] dst [2];
        logic [1:0] tnew [2];
        bit s = 0;
        dst[0] = A3_E; tnew[0] = Tnew_E;
        dst[1] = A3_M; tnew[1] = Tnew_M;
        for (int i = 0; i < 2; i++)
            if (r != 0 && r == dst[i] && int'(tuse) < int'(tnew[i])) s = 1;
        return s;
    endfunction

    task automatic idle_inputs();
        Reset = 0; Rs_D = 0; Rt_D = 0; TuseRs_D = 0; TuseRt_D = 0; MdUse_D = 0;
        A3_E = 0; Tnew_E = 0; A3_M = 0; Tnew_M = 0; Start_E = 0; MdOp_E = 0;
    endtask

    // Inputs are set shortly after a posedge; check outputs, then advance one clock and update the model.
    task automatic step();
        bit m_busy, m_stall;
        #2;
        m_busy  = (cyc <= busy_end);
        m_stall = hazard(Rs_D, TuseRs_D) || hazard(Rt_D, TuseRt_D) ||
                  (MdUse_D && (m_busy || Start_E));
        check("DregEn", 32'(DregEn), 32'(!m_stall));
        check("PcEn", 32'(PcEn), 32'(!m_stall));
        check("EregFlush", 32'(EregFlush), 32'(m_stall));
        check("Busy", 32'(Busy), 32'(m_busy));
`ifdef STALL_STAT_EN
        check("StallCnt", StallCnt, 32'(stat_model));
`endif
        obs_dreg = DregEn;
        obs_busy = Busy;
        @(posedge Clk);
        if (Reset) begin
            busy_end   = cyc;
            stat_model = 0;
        end else begin
            if (Start_E && !m_busy) busy_end = cyc + (MdOp_E ? 10 : 5);
            if (m_stall && stat_model < 64'hFFFF_FFFF) stat_model++;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        step();
        step();
        Reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();
        @(posedge Clk); #1;
        do_reset();

        // Idle after reset
        step();
        check("rst_dreg", 32'(obs_dreg), 32'd1);
        check("rst_busy", 32'(obs_busy), 32'd0);

        // Rs hazard against E, then the same with r0
        Rs_D = 5; TuseRs_D = 0; A3_E = 5; Tnew_E = 1;
        step();
        check("rs_hazard", 32'(obs_dreg), 32'd0);
        Rs_D = 0; A3_E = 0;
        step();
        check("rs_zero", 32'(obs_dreg), 32'd1);
        idle_inputs();

        // Rt against M
        Rt_D = 8; TuseRt_D = 1; A3_M = 8; Tnew_M = 1;
        step();
        check("rt_tnew1", 32'(obs_dreg), 32'd1);
        Tnew_M = 2;
        step();
        check("rt_tnew2", 32'(obs_dreg), 32'd0);
        TuseRt_D = 3;
        step();
        check("rt_unused", 32'(obs_dreg), 32'd1);
        idle_inputs();

        // Mult then div with MdUse_D held
        for (int op = 0; op < 2; op++) begin
            n = 0;
            MdUse_D = 1; Start_E = 1; MdOp_E = op[0];
            step();
            if (!obs_dreg) n++;
            Start_E = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (!obs_dreg) n++;
            end
            check(op ? "div_stalls" : "mult_stalls", 32'(n), op ? 32'd11 : 32'd6);
            idle_inputs();
        end

        // Reset at Busy cycle 4 of a div, with a simultaneous Start_E
        Start_E = 1; MdOp_E = 1;
        step();
        Start_E = 0;
        step(); step(); step();
        Reset = 1; Start_E = 1; MdOp_E = 0;
        step();
        Reset = 0; Start_E = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (obs_busy) n++;
        end
        check("rst_mid_busy", 32'(n), 32'd0);

        // Start while counting is ignored
        Start_E = 1; MdOp_E = 0;
        step();
        Start_E = 0;
        n = 0;
        step(); if (obs_busy) n++;
        step(); if (obs_busy) n++;
        Start_E = 1; MdOp_E = 1;
        step(); if (obs_busy) n++;
        Start_E = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (obs_busy) n++;
        end
        check("restart_ignored", 32'(n), 32'd5);

`ifdef STALL_STAT_EN
        do_reset();
        Rs_D = 3; TuseRs_D = 0; A3_E = 3; Tnew_E = 2;
        step(); step(); step();
        idle_inputs();
        step(); step();
        #2;
        check("stat_three", StallCnt, 32'd3);
`endif

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Rs_D     = 5'($urandom_range(0, 3));
            Rt_D     = 5'($urandom_range(0, 3));
            A3_E     = 5'($urandom_range(0, 3));
            A3_M     = 5'($urandom_range(0, 3));
            TuseRs_D = 2'($urandom_range(0, 3));
            TuseRt_D = 2'($urandom_range(0, 3));
            Tnew_E   = 2'($urandom_range(0, 2));
            Tnew_M   = 2'($urandom_range(0, 2));
            MdUse_D  = 1'($urandom_range(0, 1));
            Start_E  = ($urandom_range(0, 7) == 0);
            MdOp_E   = 1'($urandom_range(0, 1));
            Reset    = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
